// File: rtl/uart_pkg.sv
// Shared types and 16550 register map for the UART TX feeder.
package uart_pkg;

  // Feeder sequencer states: five init writes, then the runtime loop.
  typedef enum logic [3:0] {
    I_LCRD,
    I_DLL,
    I_DLM,
    I_LCR,
    I_FCR,
    IDLE,
    POLL,
    POLL_W,
    SEND,
    CRD,
    CRD_W
  } feeder_state_t;

  // 16550 register addresses (address 0 is DLL while LCR.DLAB is set).
  localparam logic [2:0] UART_THR = 3'd0;
  localparam logic [2:0] UART_DLM = 3'd1;
  localparam logic [2:0] UART_FCR = 3'd2;
  localparam logic [2:0] UART_LCR = 3'd3;
  localparam logic [2:0] UART_LSR = 3'd5;

  // Register bit positions.
  localparam int LSR_THRE = 5;
  localparam int LCR_DLAB = 7;

  // FCR: enable FIFOs and clear both of them.
  localparam logic [7:0] FCR_VAL = 8'h07;

endpackage

// File: rtl/uart_byte_fifo.sv
// Byte FIFO with first-word-fall-through head, registered level and full.
module uart_byte_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          full_q, full_d;
  logic          push_ok;
  logic          pop_ok;

  // A push while full is dropped even if a pop happens in the same cycle.
  assign push_ok = push && !full_q;
  assign pop_ok  = pop && (level_q != '0);

  // Pointer and occupancy update; pointers wrap modulo DEPTH.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    level_d  = level_q + LW'(push_ok) - LW'(pop_ok);
    full_d   = (level_d == LW'(DEPTH));
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; the pointers alone define which entries are valid.
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = (level_q == '0);
  assign level = level_q;

endmodule

// File: rtl/uart_tx_feeder.sv
// Programs a 16550 after reset, then drains a local byte FIFO into THR in
// THRE-gated bursts and passes CPU register reads through with priority.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned BURST   = 16,
  parameter logic [15:0] DIVISOR = 16'd54,
  parameter logic [7:0]  LCR_VAL = 8'h03
) (
  input  logic                   clk,
  input  logic                   Rst,
  input  logic                   tx_push,
  input  logic [7:0]             tx_byte,
  output logic                   tx_full,
  output logic [$clog2(DEPTH):0] tx_level,
  output logic                   tx_ovf,
  output logic                   init_done,
  input  logic                   cpu_rd_req,
  input  logic [2:0]             cpu_rd_addr,
  output logic [7:0]             cpu_rd_data,
  output logic                   cpu_rd_valid,
  output logic                   tx_wen,
  output logic                   rx_ren,
  output logic [2:0]             uart_addr,
  output logic [7:0]             uart_din,
  input  logic [7:0]             uart_dout
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;
  localparam int unsigned BW = $clog2(BURST) + 1;

  feeder_state_t state_q, state_d;
  logic [BW-1:0] burst_q, burst_d;
  logic          pend_q, pend_d;
  logic [2:0]    pend_addr_q, pend_addr_d;
  logic          init_done_q, init_done_d;
  logic          tx_ovf_q, tx_ovf_d;
  logic          tx_wen_q, tx_wen_d;
  logic          rx_ren_q, rx_ren_d;
  logic [2:0]    uart_addr_q, uart_addr_d;
  logic [7:0]    uart_din_q, uart_din_d;
  logic [7:0]    cpu_rd_data_q, cpu_rd_data_d;
  logic          cpu_rd_valid_q, cpu_rd_valid_d;

  logic          fifo_pop;
  logic [7:0]    fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [LW-1:0] fifo_level;
  logic          send_now;
  logic          pop_empties;

  uart_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (Rst),
    .push      (tx_push),
    .push_data (tx_byte),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // A pop of the last entry empties the FIFO unless a push refills it that cycle.
  assign pop_empties = (fifo_level == LW'(1)) && !tx_push;

  // Next state and registered bus outputs. Init writes are issued from the
  // current state; runtime accesses are issued on entry so that the bus
  // strobe lines up with POLL/CRD/SEND and uart_dout lines up with the _W states.
  always_comb begin
    state_d        = state_q;
    burst_d        = burst_q;
    pend_d         = pend_q;
    pend_addr_d    = pend_addr_q;
    init_done_d    = init_done_q || (state_q == IDLE);
    tx_ovf_d       = tx_ovf_q || (tx_push && fifo_full);
    tx_wen_d       = 1'b0;
    rx_ren_d       = 1'b0;
    uart_addr_d    = uart_addr_q;
    uart_din_d     = uart_din_q;
    cpu_rd_data_d  = cpu_rd_data_q;
    cpu_rd_valid_d = 1'b0;
    fifo_pop       = 1'b0;
    send_now       = 1'b0;

    // Outside IDLE a read cannot start now; hold one and drop any further ones.
    if (cpu_rd_req && !pend_q && (state_q != IDLE)) begin
      pend_d      = 1'b1;
      pend_addr_d = cpu_rd_addr;
    end

    unique case (state_q)
      I_LCRD: begin
        tx_wen_d    = 1'b1;
        uart_addr_d = UART_LCR;
        uart_din_d  = LCR_VAL | 8'(1 << LCR_DLAB);
        state_d     = I_DLL;
      end
      I_DLL: begin
        tx_wen_d    = 1'b1;
        uart_addr_d = UART_THR;
        uart_din_d  = DIVISOR[7:0];
        state_d     = I_DLM;
      end
      I_DLM: begin
        tx_wen_d    = 1'b1;
        uart_addr_d = UART_DLM;
        uart_din_d  = DIVISOR[15:8];
        state_d     = I_LCR;
      end
      I_LCR: begin
        tx_wen_d    = 1'b1;
        uart_addr_d = UART_LCR;
        uart_din_d  = LCR_VAL;
        state_d     = I_FCR;
      end
      I_FCR: begin
        tx_wen_d    = 1'b1;
        uart_addr_d = UART_FCR;
        uart_din_d  = FCR_VAL;
        state_d     = IDLE;
      end
      IDLE: begin
        if (pend_q) begin
          rx_ren_d    = 1'b1;
          uart_addr_d = pend_addr_q;
          pend_d      = 1'b0;
          state_d     = CRD;
        end else if (cpu_rd_req) begin
          rx_ren_d    = 1'b1;
          uart_addr_d = cpu_rd_addr;
          state_d     = CRD;
        end else if (!fifo_empty) begin
          rx_ren_d    = 1'b1;
          uart_addr_d = UART_LSR;
          state_d     = POLL;
        end
      end
      CRD:    state_d = CRD_W;
      CRD_W: begin
        cpu_rd_data_d  = uart_dout;
        cpu_rd_valid_d = 1'b1;
        state_d        = IDLE;
      end
      POLL:   state_d = POLL_W;
      POLL_W: begin
        if (uart_dout[LSR_THRE]) begin
          send_now = 1'b1;
          burst_d  = BW'(1);
        end else begin
          state_d = IDLE;
        end
      end
      SEND: begin
        send_now = 1'b1;
        burst_d  = burst_q + BW'(1);
      end
      default: state_d = I_LCRD;
    endcase

    // One THR write per cycle; stop on the pop that empties the FIFO or on the last burst slot.
    if (send_now) begin
      tx_wen_d    = 1'b1;
      uart_addr_d = UART_THR;
      uart_din_d  = fifo_head;
      fifo_pop    = 1'b1;
      state_d     = (pop_empties || (burst_d == BW'(BURST))) ? IDLE : SEND;
    end
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      state_q        <= I_LCRD;
      burst_q        <= '0;
      pend_q         <= 1'b0;
      pend_addr_q    <= '0;
      init_done_q    <= 1'b0;
      tx_ovf_q       <= 1'b0;
      tx_wen_q       <= 1'b0;
      rx_ren_q       <= 1'b0;
      uart_addr_q    <= '0;
      uart_din_q     <= '0;
      cpu_rd_data_q  <= '0;
      cpu_rd_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      burst_q        <= burst_d;
      pend_q         <= pend_d;
      pend_addr_q    <= pend_addr_d;
      init_done_q    <= init_done_d;
      tx_ovf_q       <= tx_ovf_d;
      tx_wen_q       <= tx_wen_d;
      rx_ren_q       <= rx_ren_d;
      uart_addr_q    <= uart_addr_d;
      uart_din_q     <= uart_din_d;
      cpu_rd_data_q  <= cpu_rd_data_d;
      cpu_rd_valid_q <= cpu_rd_valid_d;
    end
  end

  assign tx_full      = fifo_full;
  assign tx_level     = fifo_level;
  assign tx_ovf       = tx_ovf_q;
  assign init_done    = init_done_q;
  assign cpu_rd_data  = cpu_rd_data_q;
  assign cpu_rd_valid = cpu_rd_valid_q;
  assign tx_wen       = tx_wen_q;
  assign rx_ren       = rx_ren_q;
  assign uart_addr    = uart_addr_q;
  assign uart_din     = uart_din_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder with a small 16550 register model.
module tb_uart_tx_feeder;

  logic       clk = 1'b0;
  logic       Rst;
  logic       tx_push;
  logic [7:0] tx_byte;
  logic       tx_full;
  logic [4:0] tx_level;
  logic       tx_ovf;
  logic       init_done;
  logic       cpu_rd_req;
  logic [2:0] cpu_rd_addr;
  logic [7:0] cpu_rd_data;
  logic       cpu_rd_valid;
  logic       tx_wen;
  logic       rx_ren;
  logic [2:0] uart_addr;
  logic [7:0] uart_din;
  logic [7:0] uart_dout = 8'h00;

  int n_cmp = 0;
  int n_err = 0;

  // 16550 model controls (written only by the stimulus block).
  logic [7:0] lsr_val     = 8'h60;
  logic [7:0] rd_val      = 8'h00;
  int         lsr_ready_at = 0;

  // Monitor state (written only by the monitor block).
  int          cyc   = 0;
  int          npoll = 0;
  logic [10:0] wq[$];
  int          wc[$];

  // Expected init writes {addr, data} for DIVISOR=16'h0136, LCR_VAL=8'h03.
  logic [10:0] init_tab [5] = '{{3'd3, 8'h83}, {3'd0, 8'h36}, {3'd1, 8'h01},
                                {3'd3, 8'h03}, {3'd2, 8'h07}};

  int wb;
  int np;
  int v;

  uart_tx_feeder #(
    .DEPTH   (16),
    .BURST   (16),
    .DIVISOR (16'h0136),
    .LCR_VAL (8'h03)
  ) dut (
    .clk          (clk),
    .Rst          (Rst),
    .tx_push      (tx_push),
    .tx_byte      (tx_byte),
    .tx_full      (tx_full),
    .tx_level     (tx_level),
    .tx_ovf       (tx_ovf),
    .init_done    (init_done),
    .cpu_rd_req   (cpu_rd_req),
    .cpu_rd_addr  (cpu_rd_addr),
    .cpu_rd_data  (cpu_rd_data),
    .cpu_rd_valid (cpu_rd_valid),
    .tx_wen       (tx_wen),
    .rx_ren       (rx_ren),
    .uart_addr    (uart_addr),
    .uart_din     (uart_din),
    .uart_dout    (uart_dout)
  );

  always #5 clk = ~clk;

  // 16550 model and bus monitor: read data valid the cycle after rx_ren;
  // LSR reads return 00 until lsr_ready_at reads have been seen.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rx_ren) begin
      if (uart_addr == 3'd5) begin
        uart_dout <= (npoll < lsr_ready_at) ? 8'h00 : lsr_val;
        npoll     <= npoll + 1;
      end else begin
        uart_dout <= rd_val;
      end
    end
    if (tx_wen) begin
      wq.push_back({uart_addr, uart_din});
      wc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    Rst = 1'b0; tx_push = 1'b0; tx_byte = 8'h00; cpu_rd_req = 1'b0; cpu_rd_addr = 3'd0;

    // Reset state.
    #3;
    check("rst_wen", tx_wen, 1'b0);
    check("rst_ren", rx_ren, 1'b0);
    check("rst_bus", {uart_addr, uart_din}, 11'h0);
    check("rst_flags", {init_done, tx_full, tx_ovf, cpu_rd_valid}, 4'h0);
    check("rst_level", tx_level, 5'd0);
    check("rst_rdata", cpu_rd_data, 8'h00);
    step(); step();
    Rst = 1'b1;

    // Init sequence: cycles 1-5 write, init_done from cycle 6.
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("init_wen_%0d", k), tx_wen, 1'b1);
      check($sformatf("init_wr_%0d", k), {uart_addr, uart_din}, init_tab[k]);
      check($sformatf("init_done_lo_%0d", k), init_done, 1'b0);
    end
    step();
    check("init_done_hi", init_done, 1'b1);
    check("init_quiet", tx_wen, 1'b0);

    // Three bytes, THRE set: one poll, three consecutive THR writes.
    wb = wq.size(); np = npoll;
    for (int i = 0; i < 3; i++) begin
      tx_push = 1'b1; tx_byte = 8'h41 + 8'(i);
      step();
    end
    tx_push = 1'b0;
    for (int k = 0; k < 20; k++) step();
    check("abc_count", wq.size() - wb, 3);
    for (int i = 0; i < 3; i++)
      check($sformatf("abc_data_%0d", i), wq[wb + i], {3'd0, 8'h41 + 8'(i)});
    check("abc_consec", wc[wb + 2] - wc[wb], 2);
    check("abc_polls", npoll - np, 1);
    check("abc_level", tx_level, 5'd0);

    // Twenty pushes with THR busy: full at 16, overflow, nothing written.
    lsr_ready_at = 32'h7fff_ffff;
    wb = wq.size();
    for (int i = 0; i < 20; i++) begin
      tx_push = 1'b1; tx_byte = 8'h10 + 8'(i);
      step();
      if (i == 14) begin
        check("fill_level15", tx_level, 5'd15);
        check("fill_notfull", tx_full, 1'b0);
      end
      if (i == 15) begin
        check("fill_full", tx_full, 1'b1);
        check("fill_noovf", tx_ovf, 1'b0);
      end
    end
    tx_push = 1'b0;
    check("ovf_set", tx_ovf, 1'b1);
    check("ovf_level", tx_level, 5'd16);
    check("busy_nowrites", wq.size() - wb, 0);

    // Release THR; push two more during the burst (push+pop keeps level).
    lsr_ready_at = npoll;
    for (int k = 0; k < 20 && tx_wen !== 1'b1; k++) step();
    check("burst_started", tx_wen, 1'b1);
    check("burst_lvl_a", tx_level, 5'd15);
    tx_push = 1'b1; tx_byte = 8'hA0;
    step();
    check("pushpop_lvl_a", tx_level, 5'd15);
    tx_byte = 8'hB0;
    step();
    check("pushpop_lvl_b", tx_level, 5'd15);
    tx_push = 1'b0;
    for (int k = 0; k < 40; k++) step();
    check("burst_count", wq.size() - wb, 18);
    for (int i = 0; i < 16; i++)
      check($sformatf("burst_data_%0d", i), wq[wb + i], {3'd0, 8'h10 + 8'(i)});
    check("burst_consec", wc[wb + 15] - wc[wb], 15);
    check("burst_gap", wc[wb + 16] - wc[wb + 15], 3);
    check("tail_a", wq[wb + 16], {3'd0, 8'hA0});
    check("tail_b", wq[wb + 17], {3'd0, 8'hB0});
    check("burst_level", tx_level, 5'd0);
    check("ovf_sticky", tx_ovf, 1'b1);

    // LSR busy three times, then THRE: level next cycle, poll the cycle after.
    lsr_val = 8'h20;
    lsr_ready_at = npoll + 3;
    np = npoll; wb = wq.size();
    tx_push = 1'b1; tx_byte = 8'h77;
    step();
    tx_push = 1'b0;
    check("empty_push_level", tx_level, 5'd1);
    check("empty_push_nopoll", rx_ren, 1'b0);
    step();
    check("first_poll", {rx_ren, uart_addr}, {1'b1, 3'd5});
    for (int k = 0; k < 30; k++) step();
    check("busy_polls", npoll - np, 4);
    check("busy_writes", wq.size() - wb, 1);
    check("busy_data", wq[wb], {3'd0, 8'h77});

    // CPU read from IDLE: valid exactly 3 cycles after the request.
    rd_val = 8'hC3;
    cpu_rd_req = 1'b1; cpu_rd_addr = 3'd3;
    step();
    cpu_rd_req = 1'b0;
    check("idle_rd_strobe", {rx_ren, uart_addr}, {1'b1, 3'd3});
    step();
    check("idle_rd_c2", cpu_rd_valid, 1'b0);
    step();
    check("idle_rd_valid", cpu_rd_valid, 1'b1);
    check("idle_rd_data", cpu_rd_data, 8'hC3);
    step();
    check("idle_rd_pulse", cpu_rd_valid, 1'b0);

    // CPU read during a burst: served right after the last THR write.
    lsr_val = 8'h60; rd_val = 8'h5A;
    wb = wq.size();
    for (int i = 0; i < 5; i++) begin
      tx_push = 1'b1; tx_byte = 8'hC0 + 8'(i);
      step();
    end
    tx_push = 1'b0;
    check("in_burst", tx_wen, 1'b1);
    cpu_rd_req = 1'b1; cpu_rd_addr = 3'd0;
    step();
    cpu_rd_req = 1'b0;
    for (int k = 0; k < 30 && cpu_rd_valid !== 1'b1; k++) step();
    v = cyc;
    check("burst_rd_valid", cpu_rd_valid, 1'b1);
    check("burst_rd_data", cpu_rd_data, 8'h5A);
    check("burst_rd_addr", uart_addr, 3'd0);
    check("burst_rd_writes", wq.size() - wb, 5);
    check("burst_rd_last", wq[wq.size() - 1], {3'd0, 8'hC4});
    check("burst_rd_after", v - wc[wc.size() - 1], 3);
    step();
    check("burst_rd_pulse", cpu_rd_valid, 1'b0);

    // Reset mid-burst: immediate reset values, init reruns, FIFO empty.
    for (int i = 0; i < 8; i++) begin
      tx_push = 1'b1; tx_byte = 8'hD0 + 8'(i);
      step();
    end
    tx_push = 1'b0;
    check("pre_rst_burst", tx_wen, 1'b1);
    Rst = 1'b0;
    #1;
    check("mid_rst_strobes", {tx_wen, rx_ren}, 2'b00);
    check("mid_rst_bus", {uart_addr, uart_din}, 11'h0);
    check("mid_rst_flags", {init_done, tx_ovf, tx_full, cpu_rd_valid}, 4'h0);
    check("mid_rst_level", tx_level, 5'd0);
    check("mid_rst_rdata", cpu_rd_data, 8'h00);
    step(); step();
    Rst = 1'b1;
    wb = wq.size(); np = npoll;
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("reinit_wr_%0d", k), {tx_wen, uart_addr, uart_din}, {1'b1, init_tab[k]});
    end
    step();
    check("reinit_done", init_done, 1'b1);
    for (int k = 0; k < 10; k++) step();
    check("reinit_level", tx_level, 5'd0);
    check("reinit_writes", wq.size() - wb, 5);
    check("reinit_polls", npoll - np, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_feeder.md
# uart_tx_feeder

Register-port front end that sits directly upstream of `uart_controller` and drives its 16550 register interface (`uart_addr`, `uart_din`, `tx_wen`, `rx_ren`). After reset it programs the 16550 (divisor, line format, FIFO enable). It then drains a local byte FIFO, filled by CPU stores, into THR in bursts gated by the LSR THRE bit. CPU register reads are passed through with priority over background polling.

## Interface
- `DEPTH`, 16: local TX FIFO entries; power of two.
- `BURST`, 16: maximum THR writes per THRE poll; matches the 16550 TX FIFO depth.
- `DIVISOR`, 16'd54: baud divisor written to DLL/DLM.
- `LCR_VAL`, 8'h03: line control value (8N1).
- `clk` in 1: system clock.
- `Rst` in 1: asynchronous, active-low reset.
- `tx_push` in 1: CPU store of one byte to the TX stream.
- `tx_byte` in 8: data for `tx_push`.
- `tx_full` out 1: FIFO holds `DEPTH` entries.
- `tx_level` out $clog2(DEPTH)+1: FIFO occupancy.
- `tx_ovf` out 1: sticky; set when a push arrives while full. Cleared only by reset.
- `init_done` out 1: the 16550 programming sequence has completed.
- `cpu_rd_req` in 1: single-cycle request for a CPU register read.
- `cpu_rd_addr` in 3: 16550 register address for the read.
- `cpu_rd_data` out 8: returned register value.
- `cpu_rd_valid` out 1: one-cycle pulse that qualifies `cpu_rd_data`.
- `tx_wen` out 1: 16550 write strobe.
- `rx_ren` out 1: 16550 read strobe.
- `uart_addr` out 3: 16550 register address.
- `uart_din` out 8: write data to the 16550.
- `uart_dout` in 8: 16550 read data, valid the cycle after `rx_ren`.

## Operation
- States:
  - `I_LCRD`: write LCR = 8'h80|`LCR_VAL`.
  - `I_DLL`: write 0 ← `DIVISOR[7:0]`.
  - `I_DLM`: write 1 ← `DIVISOR[15:8]`.
  - `I_LCR`: write 3 ← `LCR_VAL`.
  - `I_FCR`: write 2 ← 8'h07.
  - `IDLE`, `POLL`, `POLL_W`, `SEND`, `CRD`, `CRD_W`.
- Every `I_*` state issues one write and advances unconditionally. Leaving `I_FCR` goes to `IDLE` and sets `init_done`.
- `IDLE` priority:
  1. A pending CPU read goes to `CRD`.
  2. Otherwise, a non-empty FIFO goes to `POLL`.
  3. Otherwise, stay in `IDLE`.
- `CRD`: `rx_ren`=1, `uart_addr`=latched `cpu_rd_addr`; next state `CRD_W`.
- `CRD_W`: capture `uart_dout` into `cpu_rd_data` and pulse `cpu_rd_valid`; return to `IDLE`.
- `POLL`: `rx_ren`=1, `uart_addr`=5 (LSR); next state `POLL_W`.
- `POLL_W`: if `uart_dout[5]`=1, go to `SEND` and clear the burst counter; otherwise go to `IDLE`.
- `SEND`: each cycle, `tx_wen`=1, `uart_addr`=0, `uart_din`=FIFO head, pop one entry, increment the burst counter. Return to `IDLE` after the pop that empties the FIFO or after the `BURST`th write, whichever comes first.
- `cpu_rd_req` that arrives during the `I_*`, `POLL`/`POLL_W` or `SEND` states is latched as pending; one pending request is held. A second request while one is pending is dropped. After `init_done` a pending read is served within `BURST`+3 cycles.
- `tx_push` is accepted in every state, including during init. A push while full is discarded and sets `tx_ovf`.
- Simultaneous push and pop: occupancy is unchanged. The new byte is written behind the head; it is never sent before older bytes.
- Push into an empty FIFO: `tx_level` updates next cycle; the earliest `POLL` follows one cycle later.
- FIFO pointers are `$clog2(DEPTH)` bits and wrap modulo `DEPTH`. Occupancy ranges 0..`DEPTH`.

## Timing
- Reset values (asynchronous, `Rst`=0): state `I_LCRD`; FIFO empty; `tx_level`=0; `tx_full`=0; `tx_ovf`=0; `init_done`=0; `tx_wen`=0; `rx_ren`=0; `uart_addr`=0; `uart_din`=0; `cpu_rd_data`=0; `cpu_rd_valid`=0; pending flag cleared.
- All outputs are registered; strobes are exactly one cycle per access.
- Init writes occupy cycles 1–5 after reset release; `init_done`=1 from cycle 6.
- Fixed overhead per burst is 2 cycles (`POLL`, `POLL_W`), then N write cycles, with N ≤ `BURST`.
- CPU read latency: `cpu_rd_valid` 3 cycles after `cpu_rd_req` when the FSM is in `IDLE`.
- Reset asserted mid-burst: bytes already written to THR are not tracked, the FIFO contents are lost, and the init sequence reruns.

## Structure
- Package `uart_pkg`:
  - state enum `feeder_state_t`;
  - register address constants: `UART_THR`=0, `UART_DLM`=1, `UART_FCR`=2, `UART_LCR`=3, `UART_LSR`=5;
  - bit constants: `LSR_THRE`=5, `LCR_DLAB`=7.
- One sub-module, `uart_byte_fifo`: synchronous FIFO with push/pop, full/empty, level and first-word-fall-through head. The FSM stays in `uart_tx_feeder`.

## Test plan
- Reset release with `DIVISOR`=16'h0136 -> writes in order: (3,8'h83), (0,8'h36), (1,8'h01), (3,8'h03), (2,8'h07); `init_done` high at cycle 6.
- Push 8'h41, 8'h42, 8'h43; LSR model returns 8'h60 -> one `POLL`, then three THR writes 41, 42, 43 on consecutive cycles; `tx_level` returns to 0.
- Push 20 bytes (DEPTH=16) -> `tx_full` after 16 pushes, `tx_ovf`=1, 4 bytes dropped; the first burst sends exactly 16 bytes.
- LSR returns 8'h00 three times, then 8'h20 -> three poll cycles with no THR writes, then the burst proceeds.
- `cpu_rd_req` with addr 0 during a `SEND` burst, `uart_dout`=8'h5A -> the read is served right after the burst and `cpu_rd_valid` pulses with 8'h5A.
- `Rst` low mid-burst -> all outputs at reset values immediately; after release, the init sequence repeats and the FIFO is empty.
